// File: rtl/ring_decoder.sv
// Ring-counter phase decoder: decodes one-hot phase lines from a 4-stage ring
// counter, tracks sequence lock, and counts sequencing faults seen while locked.
module ring_decoder #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             q0,
   input  logic             q1,
   input  logic             q2,
   input  logic             q3,
   input  logic             clr_err,
   output logic [1:0]       phase,
   output logic             phase_valid,
   output logic             locked,
   output logic             seq_err,
   output logic [ERR_W-1:0] err_cnt
);

   // state    | meaning
   // UNLOCKED | no usable history; waiting for any legal sample
   // ACQUIRE  | counting consecutive in-sequence legal samples toward lock
   // LOCKED   | sequence trusted; any illegal/out-of-sequence sample is a fault
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t           state_q, state_d;
   logic [3:0]       good_q, good_d;
   logic [1:0]       phase_q, phase_d;
   logic             phase_valid_q, phase_valid_d;
   logic             locked_q, locked_d;
   logic             seq_err_q, seq_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [3:0]       q_vec;
   logic             legal;
   logic [1:0]       enc;
   logic             in_seq;
   logic [3:0]       good_inc;

   // Decode the sample: legal only when exactly one line is high.
   always_comb begin
      q_vec = {q3, q2, q1, q0};
      legal = 1'b1;
      enc   = 2'd0;
      case (q_vec)
         4'b0001: enc = 2'd0;
         4'b0010: enc = 2'd1;
         4'b0100: enc = 2'd2;
         4'b1000: enc = 2'd3;
         default: legal = 1'b0;
      endcase
      // A repeat of the previous phase fails this compare, so it is out-of-sequence.
      in_seq   = legal && (enc == (phase_q + 2'd1));
      good_inc = good_q + 4'd1;
   end

   // Next-state, phase tracking and fault counting.
   always_comb begin
      state_d       = state_q;
      good_d        = good_q;
      phase_d       = phase_q;
      phase_valid_d = phase_valid_q;
      seq_err_d     = 1'b0;
      err_cnt_d     = err_cnt_q;

      if (en) begin
         phase_valid_d = legal;
         if (legal) begin
            phase_d = enc;
         end
         case (state_q)
            UNLOCKED: begin
               if (legal) begin
                  good_d  = 4'd1;
                  state_d = (LOCK_TGT == 4'd1) ? LOCKED : ACQUIRE;
               end
            end
            ACQUIRE: begin
               if (!legal) begin
                  state_d = UNLOCKED;
                  good_d  = 4'd0;
               end else if (in_seq) begin
                  good_d = good_inc;
                  if (good_inc >= LOCK_TGT) begin
                     state_d = LOCKED;
                  end
               end else begin
                  // Restart the run from the new phase rather than dropping out.
                  good_d = 4'd1;
               end
            end
            LOCKED: begin
               if (!in_seq) begin
                  seq_err_d = 1'b1;
                  state_d   = UNLOCKED;
                  good_d    = 4'd0;
               end
            end
            default: begin
               state_d = UNLOCKED;
               good_d  = 4'd0;
            end
         endcase
      end

      locked_d = (state_d == LOCKED);

      // Clear wins over a coincident fault; the pulse itself still goes out.
      if (clr_err) begin
         err_cnt_d = '0;
      end else if (seq_err_d && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // Register all state and outputs; reset overrides enable and clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= UNLOCKED;
         good_q        <= 4'd0;
         phase_q       <= 2'd0;
         phase_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         seq_err_q     <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         good_q        <= good_d;
         phase_q       <= phase_d;
         phase_valid_q <= phase_valid_d;
         locked_q      <= locked_d;
         seq_err_q     <= seq_err_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign phase       = phase_q;
   assign phase_valid = phase_valid_q;
   assign locked      = locked_q;
   assign seq_err     = seq_err_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder: default instance (LOCK_CNT=4, ERR_W=8) and a
// small instance (LOCK_CNT=1, ERR_W=2) for immediate lock and counter saturation.
module tb_ring_decoder;

   logic       clk;
   logic       rst;
   logic       en;
   logic       clr_err;
   logic [3:0] qv;

   logic [1:0] phase, s_phase;
   logic       phase_valid, s_phase_valid;
   logic       locked, s_locked;
   logic       seq_err, s_seq_err;
   logic [7:0] err_cnt;
   logic [1:0] s_err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   ring_decoder #(.LOCK_CNT(4), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .en(en),
      .q0(qv[0]), .q1(qv[1]), .q2(qv[2]), .q3(qv[3]),
      .clr_err(clr_err),
      .phase(phase), .phase_valid(phase_valid), .locked(locked),
      .seq_err(seq_err), .err_cnt(err_cnt)
   );

   ring_decoder #(.LOCK_CNT(1), .ERR_W(2)) dut_s (
      .clk(clk), .rst(rst), .en(en),
      .q0(qv[0]), .q1(qv[1]), .q2(qv[2]), .q3(qv[3]),
      .clr_err(clr_err),
      .phase(s_phase), .phase_valid(s_phase_valid), .locked(s_locked),
      .seq_err(s_seq_err), .err_cnt(s_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one sample, clock it, and settle just after the edge.
   task automatic step(input logic [3:0] q, input logic e, input logic c);
      qv      = q;
      en      = e;
      clr_err = c;
      @(posedge clk);
      #1;
   endtask

   // Check the main instance outputs.
   task automatic chk(input string tag, input int unsigned ph, input int unsigned pv,
                      input int unsigned lk, input int unsigned se, input int unsigned ec);
      check({tag, ".phase"},   phase,       ph);
      check({tag, ".pv"},      phase_valid, pv);
      check({tag, ".locked"},  locked,      lk);
      check({tag, ".seq_err"}, seq_err,     se);
      check({tag, ".err_cnt"}, err_cnt,     ec);
   endtask

   // Check the small instance: locked, seq_err, err_cnt.
   task automatic chk_s(input string tag, input int unsigned lk, input int unsigned se,
                        input int unsigned ec);
      check({tag, ".s_locked"},  s_locked,  lk);
      check({tag, ".s_seq_err"}, s_seq_err, se);
      check({tag, ".s_err_cnt"}, s_err_cnt, ec);
   endtask

   localparam logic [3:0] Q0 = 4'b0001;
   localparam logic [3:0] Q1 = 4'b0010;
   localparam logic [3:0] Q2 = 4'b0100;
   localparam logic [3:0] Q3 = 4'b1000;

   initial begin
      rst = 1'b1; en = 1'b0; clr_err = 1'b0; qv = 4'b0000;
      step(Q2, 1'b1, 1'b1);
      chk("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Acquire lock on q0..q3.
      step(Q0, 1'b1, 1'b0); chk("acq0", 0, 1, 0, 0, 0);
      step(Q1, 1'b1, 1'b0); chk("acq1", 1, 1, 0, 0, 0);
      step(Q2, 1'b1, 1'b0); chk("acq2", 2, 1, 0, 0, 0);
      step(Q3, 1'b1, 1'b0); chk("acq3", 3, 1, 1, 0, 0);

      // Wrap 3->0->1 while locked.
      step(Q0, 1'b1, 1'b0); chk("wrap0", 0, 1, 1, 0, 0);
      step(Q1, 1'b1, 1'b0); chk("wrap1", 1, 1, 1, 0, 0);

      // Skip q2: fault, then restart acquisition from the next legal sample.
      step(Q3, 1'b1, 1'b0); chk("skip", 3, 1, 0, 1, 1);
      step(Q0, 1'b1, 1'b0); chk("re0", 0, 1, 0, 0, 1);
      step(Q1, 1'b1, 1'b0); chk("re1", 1, 1, 0, 0, 1);
      step(Q2, 1'b1, 1'b0); chk("re2", 2, 1, 0, 0, 1);
      step(Q3, 1'b1, 1'b0); chk("re3", 3, 1, 1, 0, 1);

      // Multi-hot while locked, then all-zero while unlocked.
      step(4'b0101, 1'b1, 1'b0); chk("multihot", 3, 0, 0, 1, 2);
      step(4'b0000, 1'b1, 1'b0); chk("zero_unl", 3, 0, 0, 0, 2);

      // Out-of-sequence inside ACQUIRE restarts the good count at 1.
      step(Q0, 1'b1, 1'b0); chk("oos_a", 0, 1, 0, 0, 2);
      step(Q2, 1'b1, 1'b0); chk("oos_b", 2, 1, 0, 0, 2);
      step(Q3, 1'b1, 1'b0); chk("oos_c", 3, 1, 0, 0, 2);
      step(Q0, 1'b1, 1'b0); chk("oos_d", 0, 1, 0, 0, 2);
      step(Q1, 1'b1, 1'b0); chk("oos_e", 1, 1, 1, 0, 2);

      // Repeated phase while locked is a fault.
      step(Q1, 1'b1, 1'b0); chk("repeat", 1, 1, 0, 1, 3);

      // Illegal sample in ACQUIRE drops back to UNLOCKED.
      step(Q2, 1'b1, 1'b0); chk("ill_a", 2, 1, 0, 0, 3);
      step(4'b0000, 1'b1, 1'b0); chk("ill_b", 2, 0, 0, 0, 3);
      step(Q3, 1'b1, 1'b0); chk("ill_c", 3, 1, 0, 0, 3);
      step(Q0, 1'b1, 1'b0); chk("ill_d", 0, 1, 0, 0, 3);
      step(Q1, 1'b1, 1'b0); chk("ill_e", 1, 1, 0, 0, 3);
      step(Q2, 1'b1, 1'b0); chk("ill_f", 2, 1, 1, 0, 3);

      // en=0 with garbage on the lines: everything holds, lock kept.
      step(4'b0000, 1'b0, 1'b0); chk("hold0", 2, 1, 1, 0, 3);
      step(Q0, 1'b0, 1'b0);      chk("hold1", 2, 1, 1, 0, 3);
      step(Q3, 1'b1, 1'b0);      chk("resume", 3, 1, 1, 0, 3);

      // Reset while locked with an in-sequence sample present.
      rst = 1'b1;
      step(Q0, 1'b1, 1'b1); chk("rst_lock", 0, 0, 0, 0, 0);
      chk_s("rst_lock", 0, 0, 0);
      rst = 1'b0;

      // Small instance: LOCK_CNT=1 locks on the first legal sample; 2-bit counter saturates.
      step(Q0, 1'b1, 1'b0); chk_s("s_lock", 1, 0, 0);
      check("s_phase", s_phase, 0);
      step(Q2, 1'b1, 1'b0); chk_s("s_f1", 0, 1, 1);
      step(Q3, 1'b1, 1'b0); chk_s("s_l1", 1, 0, 1);
      step(Q1, 1'b1, 1'b0); chk_s("s_f2", 0, 1, 2);
      step(Q2, 1'b1, 1'b0); chk_s("s_l2", 1, 0, 2);
      step(Q0, 1'b1, 1'b0); chk_s("s_f3", 0, 1, 3);
      step(Q1, 1'b1, 1'b0); chk_s("s_l3", 1, 0, 3);
      step(Q3, 1'b1, 1'b0); chk_s("s_f4", 0, 1, 3);
      step(Q0, 1'b1, 1'b0); chk_s("s_l4", 1, 0, 3);
      step(Q2, 1'b1, 1'b0); chk_s("s_f5", 0, 1, 3);
      step(Q3, 1'b1, 1'b0); chk_s("s_l5", 1, 0, 3);
      // Clear coincident with a fault: clear wins, pulse still fires.
      step(Q1, 1'b1, 1'b1); chk_s("s_clr", 0, 1, 0);
      check("s_phase_clr", s_phase, 1);
      step(4'b0000, 1'b1, 1'b0); chk_s("s_after", 0, 0, 0);
      check("s_pv_after", s_phase_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 The module SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive in-sequence legal samples needed to declare lock (legal range 1..15).
REQ-002 The module SHALL have parameter ERR_W, default 8, meaning the width of the error counter.
REQ-003 Reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  sample enable; q0..q3 sampled only on edges where en=1.
REQ-007 q0, q1, q2, q3  input  1 each  one-hot phase lines from a 4-stage ring counter; phase k = qk.
REQ-008 clr_err  input  1  synchronous clear of err_cnt.
REQ-009 phase  output  2  binary index of the last legal sample.
REQ-010 phase_valid  output  1  high when the last enabled sample was legal.
REQ-011 locked  output  1  high while the FSM is in LOCKED.
REQ-012 seq_err  output  1  one-cycle pulse on a fault detected while LOCKED.
REQ-013 err_cnt  output  ERR_W  saturating count of seq_err pulses.

Function
REQ-014 A sample SHALL be legal iff exactly one of q0..q3 is 1; all-zero and multi-hot samples are illegal.
REQ-015 Encoding SHALL be q0->0, q1->1, q2->2, q3->3.
REQ-016 The expected next phase SHALL be (prev_phase + 1) mod 4; 3->0 is a valid wrap.
REQ-017 A repeated phase (sample equals prev_phase) SHALL count as out-of-sequence.
REQ-018 Latency: all outputs SHALL update on the same rising edge that samples q0..q3 with en=1, so results are visible one cycle after the inputs are presented.
REQ-019 With en=0, phase, phase_valid, FSM state, and good count SHALL hold, and seq_err SHALL be 0.
REQ-020 On an illegal sample, phase SHALL hold its previous value and phase_valid SHALL be 0.
REQ-021 On a legal sample, phase SHALL load the encoded value and phase_valid SHALL be 1.
REQ-022 The FSM SHALL have states UNLOCKED, ACQUIRE, and LOCKED, plus a 4-bit good count.
REQ-023 UNLOCKED: on a legal sample, set good=1; go to LOCKED if LOCK_CNT=1, else ACQUIRE. On an illegal sample, stay UNLOCKED.
REQ-024 ACQUIRE with an in-sequence legal sample: increment good; go to LOCKED on the edge where good reaches LOCK_CNT.
REQ-025 ACQUIRE with a legal but out-of-sequence sample: stay ACQUIRE and set good=1, restarting from the new phase.
REQ-026 ACQUIRE with an illegal sample: go to UNLOCKED and set good=0.
REQ-027 LOCKED with an in-sequence legal sample: stay LOCKED.
REQ-028 LOCKED with an illegal or out-of-sequence sample: pulse seq_err=1 for that cycle, go to UNLOCKED, set good=0, and deassert locked on the same edge.
REQ-029 seq_err SHALL never assert outside LOCKED.
REQ-030 err_cnt SHALL increment on each seq_err and saturate at 2^ERR_W-1 without wrapping.
REQ-031 If clr_err=1, err_cnt SHALL become 0 on that edge, even when seq_err pulses on the same edge (clear wins); the seq_err pulse itself is unaffected.

Reset
REQ-032 With rst=1 at a rising edge: FSM=UNLOCKED, good=0, phase=0, phase_valid=0, locked=0, seq_err=0, err_cnt=0.
REQ-033 rst SHALL take priority over en and clr_err.
REQ-034 rst asserted mid-lock SHALL drop locked on that edge with no seq_err pulse.

Verification
REQ-035 Lock: LOCK_CNT=4, en=1, feed q0,q1,q2,q3 one per cycle -> locked=1 after the 4th edge; phase sequence 0,1,2,3; phase_valid=1 throughout.
REQ-036 Wrap: while locked, continue 3->0->1 -> locked stays 1, seq_err stays 0.
REQ-037 Fault: while locked, feed q1 then q3 (skipping q2) -> seq_err=1 for one cycle, locked=0, err_cnt=1, FSM in ACQUIRE-equivalent restart on the next legal sample.
REQ-038 Illegal input: feed q=0101 while locked -> seq_err=1, phase_valid=0, phase holds, state UNLOCKED; feed q=0000 in UNLOCKED -> no seq_err.
REQ-039 Saturation and clear: ERR_W=2, force 5 faults -> err_cnt=3; clr_err asserted on the same edge as a fault -> err_cnt=0 and seq_err=1.
REQ-040 Enable and reset: toggle en=0 mid-sequence -> outputs hold and lock is kept; rst=1 while locked -> all outputs reset next edge with seq_err=0.
